// File: rtl/gpu_launch_pkg.sv
// Shared types and widths for the kernel launch controller.
package gpu_launch_pkg;

   localparam int TC_W = 8;
   localparam int KC_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      RUN,
      RETIRE
   } launch_state_t;

endpackage

// File: rtl/launch_cmd_fifo.sv
// Pending launch-command queue: synchronous push/pop, head visible combinationally.
// A push while full is dropped, so callers gate push with !full_o.
module launch_cmd_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push_i,
   input  logic [WIDTH-1:0]             push_dat_i,
   input  logic                         pop_i,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic [WIDTH-1:0]             head_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_dat_i;
      end
   end

   // Power-of-two depth lets the pointers wrap on their own.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/kernel_launch_ctrl.sv
// Queues host launch commands and sequences the dispatcher: CLEAR, RUN until done/abort/timeout, RETIRE.
// Start follows acceptance by two cycles on an idle queue; cmd_ready drops only when the queue is full.
module kernel_launch_ctrl
   import gpu_launch_pkg::*;
#(
   parameter int unsigned QUEUE_DEPTH    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 4096,
   parameter int unsigned CYCLE_W        = 16
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               cmd_valid,
   output logic                               cmd_ready,
   input  logic [TC_W-1:0]                    cmd_thread_count,
   input  logic                               abort,
   output logic                               dispatch_reset,
   output logic                               dispatch_start,
   output logic [TC_W-1:0]                    dispatch_thread_count,
   input  logic                               dispatch_done,
   output logic                               kernel_done,
   output logic                               kernel_error,
   output logic                               busy,
   output logic [$clog2(QUEUE_DEPTH+1)-1:0]   pending,
   output logic [KC_W-1:0]                    kernels_completed,
   output logic [CYCLE_W-1:0]                 last_cycles
);

   localparam int unsigned PW = $clog2(QUEUE_DEPTH+1);

   launch_state_t     state_q, state_d;
   logic [TC_W-1:0]   cur_tc_q, cur_tc_d;
   logic [CYCLE_W-1:0] cyc_q, cyc_d;
   logic [CYCLE_W-1:0] last_q, last_d;
   logic [KC_W-1:0]   kc_q, kc_d;
   logic              ok_q, ok_d;

   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              pop;
   logic [TC_W-1:0]   head;
   logic [PW-1:0]     count;
   logic              timeout_hit;

   assign cmd_ready = !fifo_full && !reset;
   assign push      = cmd_valid && cmd_ready;

   launch_cmd_fifo #(
      .DEPTH (QUEUE_DEPTH),
      .WIDTH (TC_W)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_i     (push),
      .push_dat_i (cmd_thread_count),
      .pop_i      (pop),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .count_o    (count),
      .head_o     (head)
   );

   // Wide compare so a limit beyond the counter range can never alias.
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (64'(cyc_q) == 64'(TIMEOUT_CYCLES));

   always_comb begin
      state_d  = state_q;
      cur_tc_d = cur_tc_q;
      cyc_d    = cyc_q;
      last_d   = last_q;
      kc_d     = kc_q;
      ok_d     = ok_q;
      pop      = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop      = 1'b1;
               cur_tc_d = head;
               cyc_d    = '0;
               if (head == '0) begin
                  ok_d    = 1'b1;
                  state_d = RETIRE;
               end else begin
                  state_d = CLEAR;
               end
            end
         end
         CLEAR: begin
            cyc_d   = CYCLE_W'(1);
            state_d = RUN;
         end
         RUN: begin
            if (dispatch_done) begin
               ok_d    = 1'b1;
               state_d = RETIRE;
            end else if (abort || timeout_hit) begin
               ok_d    = 1'b0;
               state_d = RETIRE;
            end else if (cyc_q != '1) begin
               cyc_d = cyc_q + CYCLE_W'(1);
            end
         end
         RETIRE: begin
            last_d = cyc_q;
            if (ok_q && (kc_q != '1)) kc_d = kc_q + KC_W'(1);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cur_tc_q <= '0;
         cyc_q    <= '0;
         last_q   <= '0;
         kc_q     <= '0;
         ok_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cur_tc_q <= cur_tc_d;
         cyc_q    <= cyc_d;
         last_q   <= last_d;
         kc_q     <= kc_d;
         ok_q     <= ok_d;
      end
   end

   assign dispatch_reset        = (state_q != RUN);
   assign dispatch_start        = (state_q == RUN);
   assign dispatch_thread_count = cur_tc_q;
   assign kernel_done           = (state_q == RETIRE) && ok_q;
   assign kernel_error          = (state_q == RETIRE) && !ok_q;
   assign busy                  = (state_q != IDLE) || (count != '0);
   assign pending               = count;
   assign kernels_completed     = kc_q;
   assign last_cycles           = last_q;

endmodule
